mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 31 +++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the dual-port (fetch/data) memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;

  localparam int DEPTH_DEF = 64;
  localparam int WAITS_DEF = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Two-request round-robin arbiter; the last-grant register only moves on a tie,
// so after reset the data port wins the first tie and ties then alternate.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  take,
  output port_e grant,
  output logic  valid
);

  port_e last;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid = req_i | req_d;
    grant = PORT_I;
    if (req_i && req_d) grant = (last == PORT_I) ? PORT_D : PORT_I;
    else if (req_d)     grant = PORT_D;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset)                       last <= PORT_I;
    else if (take && req_i && req_d)  last <= grant;
  end

endmodule

// File: rtl/mem_responder.sv
// Single-ported word RAM serving an instruction-fetch and a data port, one
// transaction at a time, with a fixed number of wait states per access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAITS = WAITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [n-1:0] i_addr,
  output logic [n-1:0] i_rdata,
  output logic         i_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [n-1:0] d_addr,
  input  logic [n-1:0] d_wdata,
  output logic [n-1:0] d_rdata,
  output logic         d_ack,
  output logic         d_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CYCLES = 4'(WAITS);

  state_e         state;
  logic [3:0]     cnt;
  port_e          port;
  logic [AW+1:0]  addr;
  logic           we;
  logic [n-1:0]   wdata;
  logic [n-1:0]   ram [DEPTH];

  logic           req_i_live, req_d_live;
  port_e          grant;
  logic           valid;
  logic [AW-1:0]  idx;
  logic           aligned;

  // Upper address bits only select aliases of the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[n-1:AW+2], d_addr[n-1:AW+2]};

  // A request still held during its own ack cycle must not start a second access.
  assign req_i_live = i_req & ~i_ack;
  assign req_d_live = d_req & ~d_ack;

  assign idx     = addr[AW+1:2];
  assign aligned = (addr[1:0] == 2'b00);

  mem_arbiter u_arbiter (
    .clk   (clk),
    .reset (reset),
    .req_i (req_i_live),
    .req_d (req_d_live),
    .take  (state == IDLE),
    .grant (grant),
    .valid (valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      port    <= PORT_I;
      addr    <= '0;
      we      <= 1'b0;
      wdata   <= '0;
      i_ack   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            port <= grant;
            cnt  <= WAIT_CYCLES;
            if (grant == PORT_D) begin
              addr  <= d_addr[AW+1:0];
              we    <= d_we;
              wdata <= d_wdata;
            end else begin
              addr  <= i_addr[AW+1:0];
              we    <= 1'b0;
              wdata <= '0;
            end
            state <= (WAIT_CYCLES == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          if (port == PORT_I) begin
            i_ack   <= 1'b1;
            i_rdata <= aligned ? ram[idx] : '0;
          end else begin
            d_ack <= 1'b1;
            if (!aligned)  d_err   <= 1'b1;
            else if (we)   d_rdata <= wdata;
            else           d_rdata <= ram[idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately left out of reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && port == PORT_D && we && aligned)
      ram[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a table of single transactions plus hand sequences for
// arbitration ties, reset mid-access and zero-wait back-to-back fetches.
module tb_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Two instances: default wait states and zero wait states.
  logic        reset, i_req, d_req, d_we, i_ack, d_ack, d_err;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic        z_reset, z_i_req, z_d_req, z_d_we, z_i_ack, z_d_ack, z_d_err;
  logic [31:0] z_i_addr, z_d_addr, z_d_wdata, z_i_rdata, z_d_rdata;

  mem_responder #(.n(32), .DEPTH(64), .WAITS(2)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ack(i_ack), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err)
  );

  mem_responder #(.n(32), .DEPTH(64), .WAITS(0)) dut_z (
    .clk(clk), .reset(z_reset), .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata),
    .i_ack(z_i_ack), .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_rdata(z_d_rdata), .d_ack(z_d_ack), .d_err(z_d_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  // One complete transaction; checks latency, data, error flag, the clear
  // after the ack cycle, and that a request held through its ack is not reissued.
  task automatic do_txn(input bit fast, input vec_t v, input string name);
    int   k;
    bit   got, stray, ack_now;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    if (fast) begin
      if (v.is_d) begin z_d_req = 1; z_d_we = v.we; z_d_addr = v.addr; z_d_wdata = v.wdata; end
      else begin z_i_req = 1; z_i_addr = v.addr; end
    end else begin
      if (v.is_d) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
      else begin i_req = 1; i_addr = v.addr; end
    end
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(posedge clk); #1; k++;
      got = fast ? (v.is_d ? z_d_ack : z_i_ack) : (v.is_d ? d_ack : i_ack);
    end
    rd = fast ? (v.is_d ? z_d_rdata : z_i_rdata) : (v.is_d ? d_rdata : i_rdata);
    er = fast ? z_d_err : d_err;
    check({name, " ack_seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(k), fast ? 32'd2 : 32'd4);
    check({name, " rdata"}, rd, v.exp_rdata);
    if (v.is_d) check({name, " err"}, 32'(er), 32'(v.exp_err));
    @(posedge clk); #1;
    rd      = fast ? (v.is_d ? z_d_rdata : z_i_rdata) : (v.is_d ? d_rdata : i_rdata);
    ack_now = fast ? (v.is_d ? z_d_ack : z_i_ack) : (v.is_d ? d_ack : i_ack);
    check({name, " ack_clear"}, {31'd0, ack_now}, 32'd0);
    check({name, " rdata_clear"}, rd, 32'd0);
    if (fast) begin z_i_req = 0; z_d_req = 0; end
    else begin i_req = 0; d_req = 0; end
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (fast ? (z_i_ack | z_d_ack) : (i_ack | d_ack)) stray = 1;
    end
    check({name, " no_reissue"}, 32'(stray), 32'd0);
  endtask

  // Both ports request together; returns the cycle index at which each acked.
  task automatic tie(input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] exp_i, input logic [31:0] exp_d,
                     output int ik, output int dk);
    int k;
    @(negedge clk);
    i_req = 1; i_addr = ia;
    d_req = 1; d_we = 0; d_addr = da;
    k = 0; ik = 0; dk = 0;
    while ((ik == 0 || dk == 0) && k < 30) begin
      @(posedge clk); #1; k++;
      if (d_ack && dk == 0) begin dk = k; check("tie d_rdata", d_rdata, exp_d); d_req = 0; end
      if (i_ack && ik == 0) begin ik = k; check("tie i_rdata", i_rdata, exp_i); i_req = 0; end
    end
    i_req = 0; d_req = 0;
    repeat (3) @(posedge clk);
  endtask

  vec_t vecs[12];
  int   ik, dk, k, gap;
  bit   seen;

  initial begin
    vecs[0]  = '{1, 1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1, 0, 32'h13,  32'h0,        32'h0,        1};
    vecs[3]  = '{1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[4]  = '{1, 1, 32'h12,  32'h55,       32'h0,        1};
    vecs[5]  = '{1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[6]  = '{1, 1, 32'h0,   32'h1234,     32'h1234,     0};
    vecs[7]  = '{1, 0, 32'h100, 32'h0,        32'h1234,     0};
    vecs[8]  = '{0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[9]  = '{0, 0, 32'h102, 32'h0,        32'h0,        0};
    vecs[10] = '{1, 1, 32'h8,   32'h77,       32'h77,       0};
    vecs[11] = '{0, 0, 32'h108, 32'h0,        32'h77,       0};

    reset = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    z_reset = 0; z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset i_ack", {31'd0, i_ack}, 32'd0);
    check("reset d_ack", {31'd0, d_ack}, 32'd0);
    check("reset d_err", {31'd0, d_err}, 32'd0);
    check("reset i_rdata", i_rdata, 32'd0);
    check("reset d_rdata", d_rdata, 32'd0);
    @(negedge clk); reset = 1; z_reset = 1;

    for (int i = 0; i < 12; i++) do_txn(0, vecs[i], $sformatf("vec%0d", i));

    // Store 0xAAAA to 0x8, reset while waiting: no ack, old word survives.
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hAAAA;
    @(posedge clk);
    @(negedge clk); reset = 0;
    seen = 0;
    @(posedge clk); #1; seen |= d_ack;
    @(negedge clk); d_req = 0;
    @(posedge clk); #1; seen |= d_ack;
    check("abort d_rdata", d_rdata, 32'd0);
    @(negedge clk); reset = 1;
    repeat (6) begin @(posedge clk); #1; seen |= d_ack; end
    check("abort no_ack", 32'(seen), 32'd0);
    do_txn(0, '{1, 0, 32'h8, 32'h0, 32'h77, 0}, "abort reload");

    // First tie after reset goes to data; the next tie goes to instruction.
    tie(32'h10, 32'h0, 32'hDEADBEEF, 32'h1234, ik, dk);
    check("tie1 d_first", 32'(dk), 32'd4);
    check("tie1 i_second", 32'(ik), 32'd8);
    tie(32'h10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, ik, dk);
    check("tie2 i_first", 32'(ik), 32'd4);
    check("tie2 d_second", 32'(dk), 32'd8);

    // Zero wait states: seed two words, then back-to-back fetches.
    do_txn(1, '{1, 1, 32'h0, 32'h11, 32'h11, 0}, "z store0");
    do_txn(1, '{1, 1, 32'h4, 32'h22, 32'h22, 0}, "z store4");
    @(negedge clk); z_i_req = 1; z_i_addr = 32'h0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin @(posedge clk); #1; k++; seen = z_i_ack; end
    check("z fetch0 latency", 32'(k), 32'd2);
    check("z fetch0 rdata", z_i_rdata, 32'h11);
    z_i_addr = 32'h4;
    gap = 0; seen = 0;
    while (!seen && gap < 20) begin @(posedge clk); #1; gap++; seen = z_i_ack; end
    check("z fetch4 gap", 32'(gap), 32'd3);
    check("z fetch4 rdata", z_i_rdata, 32'h22);
    z_i_req = 0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
